// File: rtl/if_pc_fetch.sv
// if_pc_fetch: IF-stage PC register + single-outstanding imem fetch; gnt@T, rvalid@T+k -> IF/ID and next req @T+k+1.
// Stall parks a returned instruction in a hold buffer; redirect/flush write NOP bubbles. Optional: IF_MISALIGN_CHK_EN.
module if_pc_fetch #(
  parameter int                    PC_WIDTH   = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC   = PC_WIDTH'(32'h0000_0000),
  parameter logic [DATA_WIDTH-1:0] NOP_INST   = DATA_WIDTH'(32'h0000_0013)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pc_src,
  input  logic [PC_WIDTH-1:0]   target_pc,
  input  logic                  flush_pipeline,
  input  logic                  stall,
  output logic                  imem_req,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
`ifdef IF_MISALIGN_CHK_EN
  output logic                  if_misalign,
`endif
  output logic [PC_WIDTH-1:0]   ifid_pc,
  output logic [DATA_WIDTH-1:0] ifid_inst,
  output logic                  ifid_valid
);

  typedef struct packed {
    logic [PC_WIDTH-1:0]   pc;
    logic [DATA_WIDTH-1:0] inst;
  } fetch_t;

  localparam logic [1:0] S_START = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]          state, state_nxt;
  logic [PC_WIDTH-1:0] pc, pc_nxt;
  logic [PC_WIDTH-1:0] fpc;
  logic                drop, drop_nxt;
  fetch_t              hold_q;
  fetch_t              ifid_q, ifid_nxt;
  logic                ifid_vld_q, ifid_vld_nxt;

  logic                kill;
  logic                req_fire;
  logic                resp_fire;
  logic                resp_keep;
  logic                load_from_resp;
  logic                park;
  logic                load_from_buf;
  logic [PC_WIDTH-1:0] redirect_pc;

  assign kill           = pc_src | flush_pipeline;
  assign req_fire       = (state == S_REQ) & imem_gnt;
  assign resp_fire      = (state == S_RESP) & imem_rvalid;
  assign resp_keep      = resp_fire & ~drop & ~kill;
  assign load_from_resp = resp_keep & ~stall;
  assign park           = resp_keep & stall;
  assign load_from_buf  = (state == S_HOLD) & ~kill & ~stall;

`ifdef IF_MISALIGN_CHK_EN
  assign redirect_pc = {target_pc[PC_WIDTH-1:2], 2'b00};
`else
  assign redirect_pc = target_pc;
`endif

  assign imem_req   = (state == S_REQ);
  assign imem_addr  = pc;
  assign ifid_pc    = ifid_q.pc;
  assign ifid_inst  = ifid_q.inst;
  assign ifid_valid = ifid_vld_q;

  always_comb begin
    state_nxt = state;
    case (state)
      S_START: state_nxt = S_REQ;
      S_REQ:   if (imem_gnt) state_nxt = S_RESP;
      S_RESP: begin
        if (imem_rvalid) begin
          if (drop || kill) state_nxt = S_REQ;
          else if (stall)   state_nxt = S_HOLD;
          else              state_nxt = S_REQ;
        end
      end
      S_HOLD:  if (kill || !stall) state_nxt = S_REQ;
      default: state_nxt = S_START;
    endcase
  end

  // A killed request that is already granted (or in flight) must still be
  // drained: its response is marked for discard rather than cancelled.
  always_comb begin
    drop_nxt = drop;
    if (resp_fire)
      drop_nxt = 1'b0;
    else if (kill && (req_fire || state == S_RESP))
      drop_nxt = 1'b1;
  end

  always_comb begin
    pc_nxt = pc;
    if (pc_src)
      pc_nxt = redirect_pc;
    else if (req_fire && !flush_pipeline)
      pc_nxt = pc + PC_WIDTH'(4);
  end

  // Bubbles keep the previous ifid_pc so ID always sees a stable PC value.
  always_comb begin
    ifid_nxt     = ifid_q;
    ifid_vld_nxt = ifid_vld_q;
    if (kill) begin
      ifid_nxt.inst = NOP_INST;
      ifid_vld_nxt  = 1'b0;
    end else if (stall) begin
      ifid_nxt     = ifid_q;
      ifid_vld_nxt = ifid_vld_q;
    end else if (load_from_resp) begin
      ifid_nxt.pc   = fpc;
      ifid_nxt.inst = imem_rdata;
      ifid_vld_nxt  = 1'b1;
    end else if (load_from_buf) begin
      ifid_nxt     = hold_q;
      ifid_vld_nxt = 1'b1;
    end else begin
      ifid_nxt.inst = NOP_INST;
      ifid_vld_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_START;
      pc         <= RESET_PC;
      fpc        <= RESET_PC;
      drop       <= 1'b0;
      hold_q     <= '0;
      ifid_q.pc  <= '0;
      ifid_q.inst <= NOP_INST;
      ifid_vld_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      drop       <= drop_nxt;
      ifid_q     <= ifid_nxt;
      ifid_vld_q <= ifid_vld_nxt;
      if (req_fire)
        fpc <= pc;
      if (park) begin
        hold_q.pc   <= fpc;
        hold_q.inst <= imem_rdata;
      end
    end
  end

`ifdef IF_MISALIGN_CHK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      if_misalign <= 1'b0;
    else
      if_misalign <= pc_src & (target_pc[1:0] != 2'b00);
  end
`endif

endmodule

// File: tb/tb_if_pc_fetch.sv
// Directed bench for if_pc_fetch: inputs driven 1ns after rising edge, outputs sampled there too.
module tb_if_pc_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        pc_src;
  logic [31:0] target_pc;
  logic        flush_pipeline;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_inst;
  logic        ifid_valid;
`ifdef IF_MISALIGN_CHK_EN
  logic        if_misalign;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  if_pc_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .pc_src         (pc_src),
    .target_pc      (target_pc),
    .flush_pipeline (flush_pipeline),
    .stall          (stall),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
`ifdef IF_MISALIGN_CHK_EN
    .if_misalign    (if_misalign),
`endif
    .ifid_pc        (ifid_pc),
    .ifid_inst      (ifid_inst),
    .ifid_valid     (ifid_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; pc_src = 1'b0; target_pc = '0; flush_pipeline = 1'b0; stall = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    tick; tick;
    if (imem_req !== 1'b0)    begin n_fail++; $display("FAIL reset_req: got %0b want 0", imem_req); end n_checks++;
    if (imem_addr !== 32'h0)  begin n_fail++; $display("FAIL reset_addr: got %h want 0", imem_addr); end n_checks++;
    if (ifid_pc !== 32'h0)    begin n_fail++; $display("FAIL reset_ifid_pc: got %h want 0", ifid_pc); end n_checks++;
    if (ifid_inst !== NOP)    begin n_fail++; $display("FAIL reset_ifid_inst: got %h want %h", ifid_inst, NOP); end n_checks++;
    if (ifid_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_ifid_valid: got %0b want 0", ifid_valid); end n_checks++;
    rst = 1'b0;
    if (imem_req !== 1'b0)    begin n_fail++; $display("FAIL start_req: got %0b want 0", imem_req); end n_checks++;
    tick;
    if (imem_req !== 1'b1)    begin n_fail++; $display("FAIL first_req: got %0b want 1", imem_req); end n_checks++;
    if (imem_addr !== 32'h0)  begin n_fail++; $display("FAIL first_addr: got %h want 0", imem_addr); end n_checks++;
  endtask

  task automatic test_basic_fetch;
    exp_t e;
    imem_gnt = 1'b1;
    tick;
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
    sb.push_back('{pc: 32'h0, inst: 32'h0050_0093});
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL resp_req: got %0b want 0", imem_req); end n_checks++;
    tick;
    imem_rvalid = 1'b0;
    if (ifid_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %0b want 1", ifid_valid); end n_checks++;
    if (sb.size() == 0) begin n_fail++; $display("FAIL basic_sb: got empty want entry"); end
    else begin
      e = sb.pop_front();
      if (ifid_pc !== e.pc)     begin n_fail++; $display("FAIL basic_pc: got %h want %h", ifid_pc, e.pc); end
      if (ifid_inst !== e.inst) begin n_fail++; $display("FAIL basic_inst: got %h want %h", ifid_inst, e.inst); end
    end
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin n_fail++; $display("FAIL basic_next_req: got %0b/%h want 1/4", imem_req, imem_addr); end n_checks++;
  endtask

  task automatic test_gnt_wait;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin n_fail++; $display("FAIL gnt_wait_%0d: got %0b/%h want 1/4", i, imem_req, imem_addr); end n_checks++;
      tick;
    end
    if (ifid_valid !== 1'b0 || ifid_inst !== NOP || ifid_pc !== 32'h0) begin
      n_fail++; $display("FAIL bubble_after_load: got %0b/%h/%h want 0/%h/0", ifid_valid, ifid_inst, ifid_pc, NOP);
    end n_checks++;
    imem_gnt = 1'b1;
    tick;
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h00a0_0113;
    sb.push_back('{pc: 32'h4, inst: 32'h00a0_0113});
    tick;
    imem_rvalid = 1'b0;
    if (sb.size() == 0 || ifid_valid !== 1'b1) begin n_fail++; $display("FAIL wait_fetch_valid: got %0b want 1", ifid_valid); end
    else begin
      e = sb.pop_front();
      if (ifid_pc !== e.pc || ifid_inst !== e.inst) begin n_fail++; $display("FAIL wait_fetch_data: got %h/%h want %h/%h", ifid_pc, ifid_inst, e.pc, e.inst); end
    end
    n_checks++;
    if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL wait_next_addr: got %h want 8", imem_addr); end n_checks++;
  endtask

  task automatic test_redirect;
    exp_t e;
    imem_gnt = 1'b1;
    tick;
    imem_gnt = 1'b0; pc_src = 1'b1; target_pc = 32'h100;
    tick;
    pc_src = 1'b0;
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL redir_resp_req: got %0b want 0", imem_req); end n_checks++;
    imem_rvalid = 1'b1; imem_rdata = 32'hdead_beef;
    tick;
    imem_rvalid = 1'b0;
    if (ifid_valid !== 1'b0 || ifid_inst !== NOP) begin n_fail++; $display("FAIL redir_drop: got %0b/%h want 0/%h", ifid_valid, ifid_inst, NOP); end n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_fail++; $display("FAIL redir_addr: got %0b/%h want 1/100", imem_req, imem_addr); end n_checks++;
    imem_gnt = 1'b1; pc_src = 1'b1; target_pc = 32'h200;
    tick;
    imem_gnt = 1'b0; pc_src = 1'b0;
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL redir_gnt_issued: got req %0b want 0", imem_req); end n_checks++;
    tick;
    imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
    tick;
    imem_rvalid = 1'b0;
    if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL redir_gnt_drop: got %0b want 0", ifid_valid); end n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin n_fail++; $display("FAIL redir_gnt_addr: got %0b/%h want 1/200", imem_req, imem_addr); end n_checks++;
    imem_gnt = 1'b1;
    tick;
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0030_0193;
    sb.push_back('{pc: 32'h200, inst: 32'h0030_0193});
    tick;
    imem_rvalid = 1'b0;
    if (sb.size() == 0 || ifid_valid !== 1'b1) begin n_fail++; $display("FAIL post_redir_valid: got %0b want 1", ifid_valid); end
    else begin
      e = sb.pop_front();
      if (ifid_pc !== e.pc || ifid_inst !== e.inst) begin n_fail++; $display("FAIL post_redir_data: got %h/%h want %h/%h", ifid_pc, ifid_inst, e.pc, e.inst); end
    end
    n_checks++;
  endtask

  task automatic test_stall_hold;
    exp_t e;
    imem_gnt = 1'b1; stall = 1'b1;
    tick;
    imem_gnt = 1'b0;
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req_issued: got req %0b want 0", imem_req); end n_checks++;
    imem_rvalid = 1'b1; imem_rdata = 32'h0040_0213;
    sb.push_back('{pc: 32'h204, inst: 32'h0040_0213});
    tick;
    imem_rvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (imem_req !== 1'b0 || ifid_valid !== 1'b1 || ifid_pc !== 32'h200 || ifid_inst !== 32'h0030_0193) begin
        n_fail++; $display("FAIL stall_hold_%0d: got %0b/%0b/%h/%h want 0/1/200/00300193", i, imem_req, ifid_valid, ifid_pc, ifid_inst);
      end n_checks++;
      if (i == 0) tick;
    end
    stall = 1'b0;
    tick;
    if (sb.size() == 0 || ifid_valid !== 1'b1) begin n_fail++; $display("FAIL unstall_valid: got %0b want 1", ifid_valid); end
    else begin
      e = sb.pop_front();
      if (ifid_pc !== e.pc || ifid_inst !== e.inst) begin n_fail++; $display("FAIL unstall_data: got %h/%h want %h/%h", ifid_pc, ifid_inst, e.pc, e.inst); end
    end
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h208) begin n_fail++; $display("FAIL unstall_addr: got %0b/%h want 1/208", imem_req, imem_addr); end n_checks++;
  endtask

  task automatic test_flush_stall;
    imem_gnt = 1'b1;
    tick;
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0bad_0001; stall = 1'b1;
    tick;
    imem_rvalid = 1'b0; flush_pipeline = 1'b1;
    tick;
    flush_pipeline = 1'b0; stall = 1'b0;
    if (ifid_valid !== 1'b0 || ifid_inst !== NOP || ifid_pc !== 32'h204) begin
      n_fail++; $display("FAIL flush_hold_bubble: got %0b/%h/%h want 0/%h/204", ifid_valid, ifid_inst, ifid_pc, NOP);
    end n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h20c) begin n_fail++; $display("FAIL flush_hold_addr: got %0b/%h want 1/20c", imem_req, imem_addr); end n_checks++;
    imem_gnt = 1'b1;
    tick;
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0bad_0002; stall = 1'b1;
    tick;
    imem_rvalid = 1'b0; pc_src = 1'b1; target_pc = 32'h300;
    tick;
    pc_src = 1'b0; stall = 1'b0;
    if (ifid_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin
      n_fail++; $display("FAIL redir_hold: got %0b/%0b/%h want 0/1/300", ifid_valid, imem_req, imem_addr);
    end n_checks++;
    imem_gnt = 1'b1;
    tick;
    imem_gnt = 1'b0; flush_pipeline = 1'b1;
    tick;
    flush_pipeline = 1'b0;
    tick;
    imem_rvalid = 1'b1; imem_rdata = 32'h0bad_0003;
    tick;
    imem_rvalid = 1'b0;
    if (ifid_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h304) begin
      n_fail++; $display("FAIL flush_resp_drop: got %0b/%0b/%h want 0/1/304", ifid_valid, imem_req, imem_addr);
    end n_checks++;
  endtask

  task automatic test_wrap;
    exp_t e;
    pc_src = 1'b1; target_pc = 32'hffff_fffc;
    tick;
    pc_src = 1'b0;
    if (imem_addr !== 32'hffff_fffc) begin n_fail++; $display("FAIL wrap_redir_addr: got %h want fffffffc", imem_addr); end n_checks++;
    imem_gnt = 1'b1;
    tick;
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0293;
    sb.push_back('{pc: 32'hffff_fffc, inst: 32'h0050_0293});
    tick;
    imem_rvalid = 1'b0;
    if (sb.size() == 0 || ifid_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_valid: got %0b want 1", ifid_valid); end
    else begin
      e = sb.pop_front();
      if (ifid_pc !== e.pc || ifid_inst !== e.inst) begin n_fail++; $display("FAIL wrap_data: got %h/%h want %h/%h", ifid_pc, ifid_inst, e.pc, e.inst); end
    end
    n_checks++;
    if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_next_addr: got %h want 0", imem_addr); end n_checks++;
  endtask

  task automatic test_async_reset;
    exp_t e;
    imem_gnt = 1'b1;
    tick;
    imem_gnt = 1'b0;
    #2 rst = 1'b1;
    #1;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || ifid_valid !== 1'b0 || ifid_inst !== NOP || ifid_pc !== 32'h0) begin
      n_fail++; $display("FAIL async_rst: got %0b/%h/%0b/%h/%h want 0/0/0/%h/0", imem_req, imem_addr, ifid_valid, ifid_inst, ifid_pc, NOP);
    end n_checks++;
    tick;
    rst = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0bad_0004;
    tick;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL post_rst_req: got %0b/%h want 1/0", imem_req, imem_addr); end n_checks++;
    tick;
    imem_rvalid = 1'b0;
    if (ifid_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++; $display("FAIL post_rst_rvalid_ignored: got %0b/%0b/%h want 0/1/0", ifid_valid, imem_req, imem_addr);
    end n_checks++;
    imem_gnt = 1'b1;
    tick;
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0060_0313;
    sb.push_back('{pc: 32'h0, inst: 32'h0060_0313});
    tick;
    imem_rvalid = 1'b0;
    if (sb.size() == 0 || ifid_valid !== 1'b1) begin n_fail++; $display("FAIL post_rst_fetch_valid: got %0b want 1", ifid_valid); end
    else begin
      e = sb.pop_front();
      if (ifid_pc !== e.pc || ifid_inst !== e.inst) begin n_fail++; $display("FAIL post_rst_fetch_data: got %h/%h want %h/%h", ifid_pc, ifid_inst, e.pc, e.inst); end
    end
    n_checks++;
  endtask

`ifdef IF_MISALIGN_CHK_EN
  task automatic test_misalign;
    pc_src = 1'b1; target_pc = 32'h102;
    tick;
    pc_src = 1'b0;
    if (if_misalign !== 1'b1 || imem_addr !== 32'h100) begin n_fail++; $display("FAIL misalign_pulse: got %0b/%h want 1/100", if_misalign, imem_addr); end n_checks++;
    tick;
    if (if_misalign !== 1'b0) begin n_fail++; $display("FAIL misalign_clear: got %0b want 0", if_misalign); end n_checks++;
  endtask
`endif

  initial begin
    test_reset;
    test_basic_fetch;
    test_gnt_wait;
    test_redirect;
    test_stall_hold;
    test_flush_stall;
    test_wrap;
    test_async_reset;
`ifdef IF_MISALIGN_CHK_EN
    test_misalign;
`endif
    if (sb.size() != 0) begin n_fail++; $display("FAIL sb_drain: got %0d entries want 0", sb.size()); end n_checks++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
